// File: rtl/demux4_stream_pkg.sv
// Shared constants for the 4-way stream demux: width defaults and slot state encoding.
// No logic; imported by the slot and top modules.
// Holds no state and applies no backpressure.
package demux4_stream_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNTW  = 8;
  localparam int NUM_OUT   = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot with a wrapping delivery counter.
// A load is visible on valid/data_out the next cycle.
// Holds data stable while ready_in is low; load and deliver in one cycle pass straight through.
module demux_slot
  import demux4_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready_in,
  output logic             valid,
  output logic [WIDTH-1:0] data_out,
  output logic [CNTW-1:0]  cnt
);

  slot_state_t state;
  logic        deliver;

  assign valid   = (state == FULL);
  assign deliver = valid & ready_in;

  // The top only asserts load when the slot is EMPTY or delivering this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      data_out <= '0;
      cnt      <= '0;
    end else begin
      if (load) begin
        state    <= FULL;
        data_out <= data_in;
      end else if (deliver) begin
        state <= EMPTY;
      end
      if (deliver) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux4_stream.sv
// Routes one input stream to one of four single-entry output slots chosen by in_sel.
// Latency 1: an accepted word shows up on its output on the next cycle.
// in_ready reflects only the addressed slot, so a stalled output never blocks the others.
module demux4_stream
  import demux4_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [CNTW-1:0]  out_cnt0,
  output logic [CNTW-1:0]  out_cnt1,
  output logic [CNTW-1:0]  out_cnt2,
  output logic [CNTW-1:0]  out_cnt3,
  output logic             busy
);

  logic [3:0]       load;
  logic [WIDTH-1:0] data_arr [NUM_OUT];
  logic [CNTW-1:0]  cnt_arr  [NUM_OUT];

  assign in_ready = !out_valid[in_sel] | out_ready[in_sel];
  assign busy     = |out_valid;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    assign load[k] = in_valid & in_ready & (in_sel == 2'(k));

    demux_slot #(
      .WIDTH (WIDTH),
      .CNTW  (CNTW)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .data_in  (in_data),
      .ready_in (out_ready[k]),
      .valid    (out_valid[k]),
      .data_out (data_arr[k]),
      .cnt      (cnt_arr[k])
    );
  end

  assign out_data0 = data_arr[0];
  assign out_data1 = data_arr[1];
  assign out_data2 = data_arr[2];
  assign out_data3 = data_arr[3];
  assign out_cnt0  = cnt_arr[0];
  assign out_cnt1  = cnt_arr[1];
  assign out_cnt2  = cnt_arr[2];
  assign out_cnt3  = cnt_arr[3];

endmodule

// File: tb/tb_demux4_stream.sv
// Bench for demux4_stream: per-output expected-word queues plus delivery counts,
// with directed scenarios followed by randomized traffic.
module tb_demux4_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic [7:0]  out_cnt0, out_cnt1, out_cnt2, out_cnt3;
  logic        busy;

  demux4_stream #(.WIDTH(32), .CNTW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_cnt0  (out_cnt0),
    .out_cnt1  (out_cnt1),
    .out_cnt2  (out_cnt2),
    .out_cnt3  (out_cnt3),
    .busy      (busy)
  );

  logic [31:0] od [4];
  logic [7:0]  oc [4];
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  assign oc[0] = out_cnt0;
  assign oc[1] = out_cnt1;
  assign oc[2] = out_cnt2;
  assign oc[3] = out_cnt3;

  // Reference model: words waiting on each output, and words delivered per output.
  logic [31:0] expq [4][$];
  int          mcnt [4];
  int          n_cmp = 0;
  int          n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return (expq[in_sel].size() == 0) || out_ready[in_sel];
  endfunction

  // Model update on each edge: deliveries leave the queue, an accepted word joins its queue.
  always @(posedge clk) begin
    if (rst_n) begin
      logic       acc;
      logic [1:0] s;
      logic [31:0] d;
      acc = in_valid && model_ready();
      s   = in_sel;
      d   = in_data;
      for (int k = 0; k < 4; k++) begin
        if (expq[k].size() != 0 && out_ready[k]) begin
          void'(expq[k].pop_front());
          mcnt[k]++;
        end
      end
      if (acc) expq[s].push_back(d);
    end
  end

  // Monitor: mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [3:0] ev;
      for (int k = 0; k < 4; k++) ev[k] = (expq[k].size() != 0);
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("busy", 64'(busy), 64'(|ev));
      chk("in_ready", 64'(in_ready), 64'(model_ready()));
      for (int k = 0; k < 4; k++) begin
        if (ev[k] && out_valid[k]) chk($sformatf("out_data%0d", k), 64'(od[k]), 64'(expq[k][0]));
        chk($sformatf("out_cnt%0d", k), 64'(oc[k]), 64'(mcnt[k] % 256));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between edges; outputs must clear without any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst out_data%0d", k), 64'(od[k]), 64'd0);
      chk($sformatf("rst out_cnt%0d", k), 64'(oc[k]), 64'd0);
      expq[k].delete();
      mcnt[k] = 0;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [8];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = '0;
    for (int k = 0; k < 4; k++) mcnt[k] = 0;
    #12 rst_n = 1'b1;

    // Preload every slot, then reset.
    for (int k = 0; k < 4; k++) begin
      step();
      in_valid = 1'b1; in_sel = 2'(k); in_data = $urandom;
    end
    step();
    in_valid = 1'b0;
    step();
    chk("preload out_valid", 64'(out_valid), 64'hf);
    do_reset();

    // Single route to output 2, then a second word is refused.
    step();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF; out_ready = 4'b0000;
    step();
    chk("route out_valid", 64'(out_valid), 64'h4);
    chk("route out_data2", 64'(out_data2), 64'hDEADBEEF);
    in_data = 32'h12345678;
    #1;
    chk("route 2nd in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;

    // Back-pressure hold on output 1.
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h11;
    step();
    in_data = 32'h22;
    repeat (5) begin
      step();
      chk("hold out_data1", 64'(out_data1), 64'h11);
      chk("hold in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 4'b0010;
    step();
    chk("pass out_data1", 64'(out_data1), 64'h22);
    chk("pass out_cnt1", 64'(out_cnt1), 64'd1);
    in_valid = 1'b0;
    step();
    chk("drain out_cnt1", 64'(out_cnt1), 64'd2);
    out_ready = 4'b0000;

    // Streaming round-robin at full throughput.
    do_reset();
    out_ready = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i > 0) begin
        chk("stream valid", 64'(out_valid[(i-1)%4]), 64'd1);
        chk("stream data", 64'(od[(i-1)%4]), 64'(w[i-1]));
      end
      if (i < 8) begin
        w[i] = $urandom;
        in_valid = 1'b1; in_sel = 2'(i % 4); in_data = w[i];
        #1;
        chk("stream in_ready", 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
    end
    step();
    for (int k = 0; k < 4; k++) chk($sformatf("stream cnt%0d", k), 64'(oc[k]), 64'd2);

    // 256 deliveries on output 3 wrap its counter back to the start value.
    out_ready = 4'b1000;
    in_valid = 1'b1; in_sel = 2'd3;
    for (int i = 0; i < 256; i++) begin
      in_data = $urandom;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("wrap cnt3", 64'(out_cnt3), 64'd2);
    chk("wrap cnt0", 64'(out_cnt0), 64'd2);
    chk("wrap cnt1", 64'(out_cnt1), 64'd2);
    chk("wrap cnt2", 64'(out_cnt2), 64'd2);

    // Mid-operation reset with slots 0 and 3 full: held words are dropped.
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hA0A0A0A0;
    step();
    in_sel = 2'd3; in_data = 32'hA3A3A3A3;
    step();
    in_valid = 1'b0;
    step();
    chk("mid out_valid", 64'(out_valid), 64'h9);
    do_reset();
    out_ready = 4'b1111;
    repeat (4) begin
      step();
      chk("dropped out_valid", 64'(out_valid), 64'd0);
      chk("dropped cnt0", 64'(out_cnt0), 64'd0);
      chk("dropped cnt3", 64'(out_cnt3), 64'd0);
    end

    // Random traffic; a stalled word is held until accepted.
    for (int i = 0; i < 400; i++) begin
      logic stalled;
      stalled = in_valid && !model_ready();
      step();
      out_ready = 4'($urandom);
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom);
        in_data  = $urandom;
      end
    end
    in_valid = 1'b0;
    out_ready = 4'b1111;
    repeat (3) step();
    chk("final out_valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
